stream_split: RTL
=================

Name: stream_split

Overview:
- Two-way stream demultiplexer: the receive-side counterpart of the two-into-one tagged stream merger.
- Accepts one valid/ready upstream stream and routes each word by its tag bit, data[0]: 0 goes to output A, 1 goes to output B.
- Each output has its own FIFO of depth 2**A_WIDTH, so a stalled output does not block words destined for the other output once they are accepted.
- Data words are forwarded unmodified, including the tag bit.

Parameters:
- D_WIDTH, 6, data word width in bits; bit 0 is the routing tag; minimum 1.
- A_WIDTH, 2, FIFO address width; each FIFO holds 2**A_WIDTH words; minimum 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- up_data  input  D_WIDTH  upstream word; bit 0 selects the destination.
- up_valid  input  1  upstream word present.
- up_ready  output  1  upstream word accepted this cycle if up_valid is also high.
- down_data_a  output  D_WIDTH  head word of FIFO A.
- down_valid_a  output  1  FIFO A not empty.
- down_ready_a  input  1  sink A consumes the head word.
- down_data_b  output  D_WIDTH  head word of FIFO B.
- down_valid_b  output  1  FIFO B not empty.
- down_ready_b  input  1  sink B consumes the head word.
- count_a  output  A_WIDTH+1  occupancy of FIFO A, range 0..2**A_WIDTH.
- count_b  output  A_WIDTH+1  occupancy of FIFO B, range 0..2**A_WIDTH.

Behaviour:
- Reset, asynchronous assert and synchronous-edge release:
  - Read/write pointers and counts go to 0.
  - down_valid_a and down_valid_b = 0.
  - down_data_a and down_data_b = 0.
  - count_a and count_b = 0.
  - up_ready = 1, since both FIFOs are empty.
  - Storage RAM is not reset.
- Routing:
  - sel = up_data[0].
  - up_ready = sel ? ~full_b : ~full_a, where full_x means count_x == 2**A_WIDTH.
  - up_ready depends combinationally on up_data[0] only, never on up_valid, down_ready_a or down_ready_b.
  - push_a = up_valid & up_ready & ~sel.
  - push_b = up_valid & up_ready & sel.
- Pop:
  - pop_x = down_valid_x & down_ready_x.
  - down_valid_x = (count_x != 0), driven from registered state.
- Output data:
  - down_data_x = the storage word at rd_ptr_x when down_valid_x = 1.
  - Forced to 0 when down_valid_x = 0.
  - Must stay stable while down_valid_x = 1 and down_ready_x = 0.
- Latency:
  - A word pushed at edge N appears on down_x at or after edge N.
  - It is visible in the cycle after the push edge; there is no same-cycle fall-through.
- Pointers:
  - A_WIDTH-bit pointers, natural wrap from 2**A_WIDTH-1 to 0.
  - The write pointer advances on push; the read pointer advances on pop.
- Count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with the write and the read both performed.
- Full boundary:
  - A push is refused when full, even if a pop occurs in the same cycle; there is no bypass.
  - The freed slot is usable from the next cycle.
- Empty boundary:
  - down_ready_x is ignored while empty.
  - No pointer or count change occurs.
- Ordering:
  - Per-output order equals upstream order, restricted to that tag.
  - No word is lost, duplicated or reordered.
- Independence:
  - A full FIFO A stalls only words tagged 0; words tagged 1 continue to flow.
  - A tag-0 word waiting at the head of upstream does block later tag-1 words, because the upstream is in-order.
- up_valid low: no push; up_ready still reflects up_data[0].
- Reset mid-operation: all contents are discarded immediately; outputs return to their reset values within the same cycle.
- Simultaneous activity: pushes to one FIFO and pops from both may all occur in the same cycle.

Test Plan:
Defaults D_WIDTH=6, A_WIDTH=2 (depth 4).
1. Reset, then idle:
   - down_valid_a = down_valid_b = 0, down_data_a = down_data_b = 0, count_a = count_b = 0, up_ready = 1.
2. Push 0x02, 0x05, 0x04, 0x07 with down_ready_a = down_ready_b = 1:
   - A emits 0x02 then 0x04.
   - B emits 0x05 then 0x07.
   - Each word is visible the cycle after acceptance.
3. Fill A with down_ready_a = 0: push 0x10, 0x12, 0x14, 0x16:
   - count_a = 4.
   - up_ready = 0 for up_data = 0x18.
   - up_ready = 1 for up_data = 0x19, which is accepted; count_b = 1.
4. A full, pop and push attempted in one cycle: down_ready_a = 1 with up_data = 0x18 valid:
   - The push is refused that cycle and the pop occurs, giving count_a = 3.
   - 0x18 is accepted next cycle, giving count_a = 4.
   - Output order is 0x10, 0x12, 0x14, 0x16, 0x18.
5. Steady streaming with simultaneous push and pop on B for more than 8 words (tags all 1):
   - count_b is constant and pointers wrap.
   - Output order matches input order, with no loss.
6. Reset asserted mid-operation with count_a = 3, count_b = 2:
   - All outputs return to their reset values in the same cycle.
   - After release, no stale word is emitted.

Source files
------------

// File: rtl/stream_split.sv
// stream_split: two-way tagged stream demultiplexer.
// Each upstream word is routed by its tag bit data[0] (0 -> A, 1 -> B) into
// a per-output FIFO, so a stalled sink only blocks words bound for it.

// One output lane: a small FIFO with registered occupancy and a
// zero-forced head word while empty.
module stream_split_lane #(
    parameter int D_WIDTH = 6,
    parameter int A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               ready,
    output logic               valid,
    output logic [D_WIDTH-1:0] rdata,
    output logic               full,
    output logic [A_WIDTH:0]   count
);
    localparam int DEPTH = 1 << A_WIDTH;
    localparam logic [A_WIDTH:0] FULL_CNT = DEPTH[A_WIDTH:0];

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr, rd_ptr;
    logic               pop;

    // Valid comes straight from the registered count, so there is no
    // fall-through: a word pushed at an edge is visible only after it.
    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid & ready;
    assign rdata = valid ? mem[rd_ptr] : '0;

    // Storage is deliberately left unreset; valid gating hides stale words.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally; count tracks push/pop with both-at-once neutral.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + A_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + A_WIDTH'(1);
            case ({push, pop})
                2'b10:   count <= count + (A_WIDTH+1)'(1);
                2'b01:   count <= count - (A_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module stream_split #(
    parameter int D_WIDTH = 6,
    parameter int A_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data_a,
    output logic               down_valid_a,
    input  logic               down_ready_a,
    output logic [D_WIDTH-1:0] down_data_b,
    output logic               down_valid_b,
    input  logic               down_ready_b,
    output logic [A_WIDTH:0]   count_a,
    output logic [A_WIDTH:0]   count_b
);
    localparam int NUM_LANES = 2;

    logic                                sel;
    logic [NUM_LANES-1:0]                push, rdy, vld, full;
    logic [NUM_LANES-1:0][D_WIDTH-1:0]   dout;
    logic [NUM_LANES-1:0][A_WIDTH:0]     cnt;

    // Ready depends only on the tag and the target's fullness; a full FIFO
    // refuses even if it pops this cycle (no bypass path).
    assign sel      = up_data[0];
    assign up_ready = sel ? ~full[1] : ~full[0];
    assign push     = {up_valid & up_ready & sel, up_valid & up_ready & ~sel};
    assign rdy      = {down_ready_b, down_ready_a};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        stream_split_lane #(
            .D_WIDTH (D_WIDTH),
            .A_WIDTH (A_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .wdata (up_data),
            .ready (rdy[i]),
            .valid (vld[i]),
            .rdata (dout[i]),
            .full  (full[i]),
            .count (cnt[i])
        );
    end

    assign down_data_a  = dout[0];
    assign down_valid_a = vld[0];
    assign count_a      = cnt[0];
    assign down_data_b  = dout[1];
    assign down_valid_b = vld[1];
    assign count_b      = cnt[1];
endmodule
